// File: rtl/shift_ctr_pkg.sv
// Shared constants for the multimode shift-register counter.
package shift_ctr_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_FWD      = 1'b0;
  localparam logic DIR_REV      = 1'b1;

endpackage

// File: rtl/shift_ctr_decode.sv
// Combinational legality check and binary position decode of a ring/Johnson state.
module shift_ctr_decode
  import shift_ctr_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(2*N)
) (
  input  logic [N-1:0]  q,
  input  logic          mode,
  output logic          illegal,
  output logic [IW-1:0] idx
);

  localparam int CW = $clog2(N+1);

  logic [CW-1:0] pop;
  logic [CW-1:0] trans;
  logic [IW-1:0] pos;
  logic [IW-1:0] idx_john;

  always_comb begin
    pop   = '0;
    trans = '0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(q[i]);
      if (q[i]) pos = IW'(i);
    end
    // One contiguous run of ones means at most one bit-to-bit transition.
    for (int i = 0; i < N-1; i++) begin
      trans = trans + CW'(q[i] ^ q[i+1]);
    end
  end

  always_comb begin
    idx_john = q[N-1] ? IW'(2*N - int'(pop)) : IW'(pop);
    if (mode == MODE_RING) begin
      illegal = (pop != CW'(1));
      idx     = illegal ? '0 : pos;
    end else begin
      illegal = (trans > CW'(1));
      idx     = illegal ? '0 : idx_john;
    end
  end

endmodule

// File: rtl/shift_counter_multimode.sv
// N-bit ring/Johnson counter with enable, direction, load, self-correction,
// index decode and a registered wrap pulse.
module shift_counter_multimode
  import shift_ctr_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  q,
  output logic [IW-1:0] idx,
  output logic          illegal,
  output logic          wrap
);

  localparam logic [N-1:0]  RING_SEED = N'(1);
  localparam logic [IW-1:0] LAST_RING = IW'(N-1);
  localparam logic [IW-1:0] LAST_JOHN = IW'(2*N-1);

  logic [N-1:0]  step_val;
  logic [IW-1:0] idx_last;
  logic          at_wrap;

  shift_ctr_decode #(.N(N)) u_decode (
    .q       (q),
    .mode    (mode),
    .illegal (illegal),
    .idx     (idx)
  );

  always_comb begin
    step_val = q;
    case ({mode, dir})
      {MODE_RING,    DIR_FWD}: step_val = {q[N-2:0], q[N-1]};
      {MODE_RING,    DIR_REV}: step_val = {q[0], q[N-1:1]};
      {MODE_JOHNSON, DIR_FWD}: step_val = {q[N-2:0], ~q[N-1]};
      {MODE_JOHNSON, DIR_REV}: step_val = {~q[0], q[N-1:1]};
      default:                 step_val = q;
    endcase
    idx_last = (mode == MODE_RING) ? LAST_RING : LAST_JOHN;
    // Wrap is judged on the pre-step position: last->0 forward, 0->last reverse.
    at_wrap  = (dir == DIR_FWD) ? (idx == idx_last) : (idx == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (en && illegal) begin
      q    <= (mode == MODE_RING) ? RING_SEED : '0;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= step_val;
      wrap <= at_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_counter_multimode.sv
// Directed-vector bench for shift_counter_multimode at N = 4.
module tb_shift_counter_multimode;

  localparam int N  = 4;
  localparam int IW = $clog2(2*N);

  logic          clk;
  logic          rst;
  logic          en;
  logic          mode;
  logic          dir;
  logic          load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  q;
  logic [IW-1:0] idx;
  logic          illegal;
  logic          wrap;

  int n_vec;
  int n_err;

  shift_counter_multimode #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .idx      (idx),
    .illegal  (illegal),
    .wrap     (wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [N-1:0] eq, input logic [IW-1:0] eidx,
                           input logic eill, input logic ewrap);
    chk({tag, ".q"},       32'(q),       32'(eq));
    chk({tag, ".idx"},     32'(idx),     32'(eidx));
    chk({tag, ".illegal"}, 32'(illegal), 32'(eill));
    chk({tag, ".wrap"},    32'(wrap),    32'(ewrap));
  endtask

  // driver: advance one edge, settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [N-1:0]  j_q   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [IW-1:0] j_idx [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [N-1:0]  r_q   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [IW-1:0] r_idx [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b1; dir = 1'b0; load = 1'b0; load_val = '0;
    #12;
    rst = 1'b0;
    #1;
    chk_state("reset_john", 4'b0000, 3'd0, 1'b0, 1'b0);

    // 1. Johnson forward full cycle
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_state($sformatf("john_fwd%0d", i), j_q[i], j_idx[i], 1'b0, (i == 7));
    end

    // 2. Johnson reverse from 0000
    dir = 1'b1;
    tick();
    chk_state("john_rev0", 4'b1000, 3'd7, 1'b0, 1'b1);
    tick();
    chk_state("john_rev1", 4'b1100, 3'd6, 1'b0, 1'b0);

    // 3. Johnson illegal load then correction
    dir = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'b0101;
    tick();
    chk_state("john_load", 4'b0101, 3'd0, 1'b1, 1'b0);
    load = 1'b0; en = 1'b1;
    tick();
    chk_state("john_fix", 4'b0000, 3'd0, 1'b0, 1'b0);

    // 4. Ring from reset
    en = 1'b0; mode = 1'b0;
    do_reset();
    chk_state("ring_reset", 4'b0000, 3'd0, 1'b1, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state($sformatf("ring_fwd%0d", i), r_q[i], r_idx[i], 1'b0, (i == 4));
    end
    tick();
    chk_state("ring_after_wrap", 4'b0010, 3'd1, 1'b0, 1'b0);

    // 5. load beats en, then hold
    load = 1'b1; load_val = 4'b0011;
    tick();
    chk_state("load_pri", 4'b0011, 3'd0, 1'b1, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state($sformatf("hold%0d", i), 4'b0011, 3'd0, 1'b1, 1'b0);
    end

    // 6. async reset mid-count
    mode = 1'b1; dir = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_state("pre_rst", 4'b1110, 3'd5, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.q", 32'(q), 32'h0);
    chk("async_rst.wrap", 32'(wrap), 32'h0);
    #1;
    rst = 1'b0;
    tick();
    chk_state("resume", 4'b0001, 3'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
